// File: rtl/fetch_queue.sv
// Instruction prefetch buffer: streams sequential fetches from a combinational imem
// into a small FIFO and hands them to decode over valid/ready; redirect flushes and restarts.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic [31:0]              imem_addr,
    input  logic [31:0]              imem_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_instr,
    output logic [31:0]              out_pc,
    input  logic                     redirect_valid,
    input  logic [31:0]              redirect_pc,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   fetch_pc_reg, fetch_pc_next;
    logic [CW-1:0] count_reg, count_next;
    logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [31:0]   head_pc_reg, head_pc_next;
    logic [31:0]   head_instr_reg, head_instr_next;

    logic [31:0]   entry_pc    [DEPTH];
    logic [31:0]   entry_instr [DEPTH];

    logic pop;
    logic push;

    assign pop  = (count_reg != '0) & out_ready;
    assign push = !redirect_valid & ((count_reg < CW'(DEPTH)) | pop);

    always_comb begin
        fetch_pc_next   = fetch_pc_reg;
        count_next      = count_reg;
        rd_ptr_next     = rd_ptr_reg;
        wr_ptr_next     = wr_ptr_reg;
        head_pc_next    = head_pc_reg;
        head_instr_next = head_instr_reg;

        if (redirect_valid) begin
            fetch_pc_next = redirect_pc & 32'hFFFF_FFFC;
            count_next    = '0;
            rd_ptr_next   = '0;
            wr_ptr_next   = '0;
        end else begin
            if (pop) begin
                rd_ptr_next = rd_ptr_reg + PW'(1);
            end
            if (push) begin
                wr_ptr_next   = wr_ptr_reg + PW'(1);
                fetch_pc_next = fetch_pc_reg + 32'd4;
            end
            case ({push, pop})
                2'b10:   count_next = count_reg + CW'(1);
                2'b01:   count_next = count_reg - CW'(1);
                default: count_next = count_reg;
            endcase
        end

        // The head output is registered, so the entry being written this cycle
        // must be forwarded when it becomes the new head.
        if (count_next != '0) begin
            if (push && (wr_ptr_reg == rd_ptr_next)) begin
                head_pc_next    = fetch_pc_reg;
                head_instr_next = imem_data;
            end else begin
                head_pc_next    = entry_pc[rd_ptr_next];
                head_instr_next = entry_instr[rd_ptr_next];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            entry_pc[wr_ptr_reg]    <= fetch_pc_reg;
            entry_instr[wr_ptr_reg] <= imem_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_reg   <= RESET_PC;
            count_reg      <= '0;
            rd_ptr_reg     <= '0;
            wr_ptr_reg     <= '0;
            head_pc_reg    <= '0;
            head_instr_reg <= '0;
        end else begin
            fetch_pc_reg   <= fetch_pc_next;
            count_reg      <= count_next;
            rd_ptr_reg     <= rd_ptr_next;
            wr_ptr_reg     <= wr_ptr_next;
            head_pc_reg    <= head_pc_next;
            head_instr_reg <= head_instr_next;
        end
    end

    assign imem_addr = fetch_pc_reg;
    assign out_valid = (count_reg != '0);
    assign occupancy = count_reg;
    assign out_pc    = head_pc_reg;
    assign out_instr = head_instr_reg;

endmodule
